// File: rtl/immediate_generator_pkg.sv
// Shared definitions for the RV32I immediate generator.
// Holds the opcode constants that select an immediate format and the
// 3-bit format encoding reported on the fmt output.
package immediate_generator_pkg;

    // fmt output encoding
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } fmt_e;

    // RV32I major opcodes (instr[6:0]) that carry an immediate
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Format selection looks at the opcode only; funct fields never matter.
    function automatic fmt_e fmt_of(input logic [6:0] opc);
        fmt_e f;
        case (opc)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: f = FMT_I;
            OPC_STORE:                      f = FMT_S;
            OPC_BRANCH:                     f = FMT_B;
            OPC_LUI, OPC_AUIPC:             f = FMT_U;
            OPC_JAL:                        f = FMT_J;
            default:                        f = FMT_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/immediate_generator_imm_decode.sv
// imm_decode: purely combinational immediate extraction.
//   instr_i   [31:0]  RV32I instruction word
//   imm_o     [31:0]  sign-extended immediate (0 when no immediate)
//   fmt_o     [2:0]   decoded format (fmt_e encoding)
//   illegal_o         opcode carries no immediate
module imm_decode
    import immediate_generator_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o,
    output logic [2:0]  fmt_o,
    output logic        illegal_o
);

    fmt_e fmt;

    assign fmt = fmt_of(instr_i[6:0]);

    always_comb begin
        imm_o     = 32'h0;
        illegal_o = 1'b0;
        // instr[31] is the sign bit for every sign-extended format
        case (fmt)
            FMT_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            FMT_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            FMT_U: imm_o = {instr_i[31:12], 12'h000};
            FMT_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: illegal_o = 1'b1;
        endcase
    end

    assign fmt_o = fmt;

endmodule

// File: rtl/immediate_generator.sv
// immediate_generator: RV32I immediate decode with optional output register.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   instr valid this cycle
//   instr      [31:0] instruction word
//   out_valid  imm_out/fmt/illegal valid
//   imm_out    [31:0] sign-extended immediate
//   fmt        [2:0]  0=NONE 1=I 2=S 3=B 4=U 5=J
//   illegal    opcode carries no immediate
// OUT_REG=1: one cycle latency, data captured only on in_valid and held
// otherwise. OUT_REG=0: outputs follow instr combinationally.
module immediate_generator
    import immediate_generator_pkg::*;
#(
    parameter int OUT_REG = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] instr,
    output logic        out_valid,
    output logic [31:0] imm_out,
    output logic [2:0]  fmt,
    output logic        illegal
);

    logic [31:0] imm_d;
    logic [2:0]  fmt_d;
    logic        illegal_d;

    imm_decode u_dec (
        .instr_i   (instr),
        .imm_o     (imm_d),
        .fmt_o     (fmt_d),
        .illegal_o (illegal_d)
    );

    generate
        if (OUT_REG != 0) begin : g_reg
            logic        vld_q;
            logic [31:0] imm_q;
            logic [2:0]  fmt_q;
            logic        illegal_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q     <= 1'b0;
                    imm_q     <= 32'h0;
                    fmt_q     <= 3'd0;
                    illegal_q <= 1'b0;
                end else begin
                    vld_q <= in_valid;
                    // data holds when no new instruction arrives
                    if (in_valid) begin
                        imm_q     <= imm_d;
                        fmt_q     <= fmt_d;
                        illegal_q <= illegal_d;
                    end
                end
            end

            assign out_valid = vld_q;
            assign imm_out   = imm_q;
            assign fmt       = fmt_q;
            assign illegal   = illegal_q;
        end else begin : g_comb
            // reset still forces the outputs to zero in the pass-through build
            assign out_valid = in_valid & rst_n;
            assign imm_out   = rst_n ? imm_d : 32'h0;
            assign fmt       = rst_n ? fmt_d : 3'd0;
            assign illegal   = rst_n & illegal_d;
        end
    endgenerate

endmodule

// File: tb/tb_immediate_generator.sv
module tb_immediate_generator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;

    logic        out_valid,   out_valid_c;
    logic [31:0] imm_out,     imm_out_c;
    logic [2:0]  fmt,         fmt_c;
    logic        illegal,     illegal_c;

    int checks = 0;
    int errs   = 0;

    immediate_generator #(.OUT_REG(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .instr     (instr),
        .out_valid (out_valid),
        .imm_out   (imm_out),
        .fmt       (fmt),
        .illegal   (illegal)
    );

    immediate_generator #(.OUT_REG(0)) dut_c (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .instr     (instr),
        .out_valid (out_valid_c),
        .imm_out   (imm_out_c),
        .fmt       (fmt_c),
        .illegal   (illegal_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one valid instruction after a falling edge; check the
    // combinational instance before the rising edge and the registered
    // instance just after it.
    task automatic step(input string tag, input logic [31:0] ins,
                        input logic [31:0] e_imm, input logic [2:0] e_fmt,
                        input logic e_ill);
        @(negedge clk);
        in_valid = 1'b1;
        instr    = ins;
        #1;
        chk({tag, "_c_vld"}, {31'h0, out_valid_c}, 32'h1);
        chk({tag, "_c_imm"}, imm_out_c, e_imm);
        chk({tag, "_c_fmt"}, {29'h0, fmt_c}, {29'h0, e_fmt});
        chk({tag, "_c_ill"}, {31'h0, illegal_c}, {31'h0, e_ill});
        @(posedge clk);
        #1;
        chk({tag, "_vld"}, {31'h0, out_valid}, 32'h1);
        chk({tag, "_imm"}, imm_out, e_imm);
        chk({tag, "_fmt"}, {29'h0, fmt}, {29'h0, e_fmt});
        chk({tag, "_ill"}, {31'h0, illegal}, {31'h0, e_ill});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        instr    = 32'h00510093;
        #1;
        // reset state, even with a valid instruction present
        chk("rst_vld", {31'h0, out_valid}, 32'h0);
        chk("rst_imm", imm_out, 32'h0);
        chk("rst_fmt", {29'h0, fmt}, 32'h0);
        chk("rst_ill", {31'h0, illegal}, 32'h0);
        chk("rst_c_vld", {31'h0, out_valid_c}, 32'h0);
        chk("rst_c_imm", imm_out_c, 32'h0);
        @(posedge clk); #1;
        chk("rst_edge_vld", {31'h0, out_valid}, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        chk("rel_idle_vld", {31'h0, out_valid}, 32'h0);

        // back-to-back directed vectors
        step("addi",   32'h00510093, 32'h00000005, 3'd1, 1'b0);
        step("sw",     32'h00112A23, 32'h00000014, 3'd2, 1'b0);
        step("sw_neg", 32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0);
        step("b_b11",  32'h001100E3, 32'h00000800, 3'd3, 1'b0);
        step("b_neg",  32'h80000063, 32'hFFFFF000, 3'd3, 1'b0);
        step("lui",    32'h123450B7, 32'h12345000, 3'd4, 1'b0);
        step("auipc",  32'h00001017, 32'h00001000, 3'd4, 1'b0);
        step("jal",    32'h004000EF, 32'h00000004, 3'd5, 1'b0);
        step("jal_neg",32'h800000EF, 32'hFFF00000, 3'd5, 1'b0);
        step("addi_m1",32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
        step("lw_neg", 32'hFFC12083, 32'hFFFFFFFC, 3'd1, 1'b0);
        step("jalr",   32'h00008067, 32'h00000000, 3'd1, 1'b0);
        step("srai",   32'h40115093, 32'h00000401, 3'd1, 1'b0);
        step("rtype",  32'h00000033, 32'h00000000, 3'd0, 1'b1);
        step("lui2",   32'hABCDE037, 32'hABCDE000, 3'd4, 1'b0);

        // in_valid low: registered outputs hold, comb outputs follow instr
        @(negedge clk);
        in_valid = 1'b0;
        instr    = 32'h00000033;
        #1;
        chk("hold_c_vld", {31'h0, out_valid_c}, 32'h0);
        chk("hold_c_ill", {31'h0, illegal_c}, 32'h1);
        chk("hold_c_imm", imm_out_c, 32'h0);
        @(posedge clk); #1;
        chk("hold_vld", {31'h0, out_valid}, 32'h0);
        chk("hold_imm", imm_out, 32'hABCDE000);
        chk("hold_fmt", {29'h0, fmt}, 32'h4);
        chk("hold_ill", {31'h0, illegal}, 32'h0);

        // reset mid-stream with out_valid=1 clears at once
        step("pre_rst", 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_imm", imm_out, 32'h0);
        chk("mid_rst_fmt", {29'h0, fmt}, 32'h0);
        chk("mid_rst_ill", {31'h0, illegal}, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_vld", {31'h0, out_valid}, 32'h0);
        chk("post_rst_imm", imm_out, 32'h0);

        // first capture after reset release
        step("post_rst_sw", 32'h00112A23, 32'h00000014, 3'd2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule

// File: doc/immediate_generator.md
IMMEDIATE_GENERATOR -- requirements
Module: immediate_generator

Interface
REQ-001 Parameter OUT_REG, default 1: 1 means outputs are registered (1-cycle latency); 0 means outputs are combinational from inputs.
REQ-002 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  instr is valid this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 out_valid  output  1  imm_out/fmt/illegal valid.
REQ-008 imm_out  output  32  sign-extended immediate.
REQ-009 fmt  output  3  decoded format: 0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J.
REQ-010 illegal  output  1  opcode carries no immediate / unsupported.

Function
REQ-011 Format SHALL be selected by opcode instr[6:0] only: 0010011, 0000011, 1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; all others -> NONE.
REQ-012 I: imm = sign-extend(instr[31:20]); shift-immediate funct7 bits are NOT masked.
REQ-013 S: imm = sign-extend({instr[31:25], instr[11:7]}).
REQ-014 B: imm = sign-extend({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); bit 0 always 0.
REQ-015 U: imm = {instr[31:12], 12'h000}; no further extension.
REQ-016 J: imm = sign-extend({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}); bit 0 always 0.
REQ-017 Sign bit SHALL always be instr[31] for I/S/B/J.
REQ-018 NONE: imm_out = 0, fmt = 0, illegal = 1; otherwise illegal = 0.
REQ-019 OUT_REG=1: on each rising clk, out_valid <= in_valid; imm_out/fmt/illegal update only when in_valid=1 and hold otherwise.
REQ-020 OUT_REG=0: out_valid = in_valid; other outputs follow instr combinationally regardless of in_valid.
REQ-021 No backpressure; every in_valid cycle produces exactly one out_valid cycle; back-to-back inputs are supported at full rate.
REQ-022 Output SHALL NOT depend on funct3/funct7 or register fields except through the bit mappings above.

Reset
REQ-023 While rst_n=0 (asynchronous assertion): out_valid=0, imm_out=0, fmt=0, illegal=0.
REQ-024 Release is synchronous to clk; first capture occurs on the first rising edge with rst_n=1.
REQ-025 Reset asserted mid-stream SHALL discard any pending output immediately.

Structure
REQ-026 Shared package SHALL hold the RV32I opcode constants and the 3-bit format enum (NONE, I, S, B, U, J).
REQ-027 A combinational sub-module imm_decode (instr -> imm, fmt, illegal) SHALL be instantiated; the top adds the optional output register stage.

Verification
REQ-028 I: instr=0x00510093 (ADDI x1,x2,5) -> imm_out=0x00000005, fmt=1, out_valid one cycle later.
REQ-029 S: instr=0x00112A23 (SW x1,20(x2)) -> imm_out=0x00000014, fmt=2.
REQ-030 B: instr=0x001100E3 -> imm_out=0x00000800 (instr[7]->imm[11]), fmt=3; instr=0x80000063 -> 0xFFFFF000.
REQ-031 U: instr=0x123450B7 (LUI) -> imm_out=0x12345000, fmt=4; J: instr=0x004000EF -> imm_out=0x00000004, fmt=5.
REQ-032 Sign/illegal: instr=0xFFF00093 -> 0xFFFFFFFF; instr=0x00000033 (R-type) -> imm_out=0, illegal=1, fmt=0.
REQ-033 Reset/handshake: assert rst_n=0 between clk edges with out_valid=1 -> outputs clear immediately; in_valid low -> outputs hold previous values, out_valid=0.
